// File: rtl/offset_align_pkg.sv
// Shared types and the bitwise combine rule for the offset_align datapath.
package offset_align_pkg;

  // How the two extracted windows are merged into the result.
  typedef enum logic [1:0] {
    MODE_AND    = 2'd0,
    MODE_OR     = 2'd1,
    MODE_XOR    = 2'd2,
    MODE_PASS_A = 2'd3
  } mode_t;

  // RUN streams operand pairs. DRAIN empties the pipeline so a new
  // configuration can be swapped in without mixing configs in flight.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // One result bit from one bit of each window. Applied per bit, so the
  // window width stays a property of the instantiating module.
  function automatic logic combine(input logic a, input logic b, input mode_t mode);
    logic r;
    case (mode)
      MODE_AND: r = a & b;
      MODE_OR:  r = a | b;
      MODE_XOR: r = a ^ b;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/offset_align_if.sv
// Bundle of the configuration, operand and result channels of offset_align.
//
// Handshake rule for all three channels: a transfer happens on a rising edge
// where valid && ready are both 1. The producer keeps valid and its payload
// stable until that edge. in_ready depends combinationally on out_ready.
// cfg_ready is a registered one-cycle pulse.
interface offset_align_if #(
  parameter int A_W   = 32,
  parameter int B_W   = 16,
  parameter int OUT_W = 10
);
  import offset_align_pkg::*;

  localparam int OFF_A_W = $clog2(A_W) + 1;
  localparam int OFF_B_W = $clog2(B_W) + 1;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [OFF_A_W-1:0] cfg_off_a;
  logic [OFF_B_W-1:0] cfg_off_b;
  mode_t              cfg_mode;

  logic               in_valid;
  logic               in_ready;
  logic [A_W-1:0]     in_a;
  logic [B_W-1:0]     in_b;

  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_y;
  logic               out_ovf;
  logic [15:0]        out_cnt;

  // Block side.
  modport slave (
    input  cfg_valid, cfg_off_a, cfg_off_b, cfg_mode,
    input  in_valid, in_a, in_b,
    input  out_ready,
    output cfg_ready, in_ready,
    output out_valid, out_y, out_ovf, out_cnt
  );

  // Producer/consumer side.
  modport master (
    output cfg_valid, cfg_off_a, cfg_off_b, cfg_mode,
    output in_valid, in_a, in_b,
    output out_ready,
    input  cfg_ready, in_ready,
    input  out_valid, out_y, out_ovf, out_cnt
  );

endinterface

// File: rtl/offset_slice.sv
// Zero-filled window extraction: o_win[i] = i_data[i_off+i], or 0 when that
// bit lies beyond IN_W. o_ovf flags that the window ran past the operand.
module offset_slice #(
  parameter int  IN_W  = 32,
  parameter int  OUT_W = 10,
  localparam int OFF_W = $clog2(IN_W) + 1
) (
  input  logic [IN_W-1:0]  i_data,
  input  logic [OFF_W-1:0] i_off,
  output logic [OUT_W-1:0] o_win,
  output logic             o_ovf
);
  import offset_align_pkg::*;

  // Padding above the operand supplies the zero fill; shifting by at least
  // the full padded width yields an all-zero window.
  assign o_win = OUT_W'({{OUT_W{1'b0}}, i_data} >> i_off);

  // Compared in 32 bits so off+OUT_W cannot wrap.
  assign o_ovf = (32'(i_off) + 32'(OUT_W)) > 32'(IN_W);

endmodule

// File: rtl/offset_align.sv
// Two-stage slice/align/combine unit. S1 holds both windows and the ovf flag.
// S2 holds the combined result. Reconfiguration drains the pipeline first.
module offset_align
  import offset_align_pkg::*;
#(
  parameter int    A_W       = 32,
  parameter int    B_W       = 16,
  parameter int    OUT_W     = 10,
  parameter int    DEF_OFF_A = 0,
  parameter int    DEF_OFF_B = 1,
  parameter mode_t DEF_MODE  = MODE_OR,
  parameter bit    FORCE_EN  = 1'b1,
  parameter bit    FORCE_VAL = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  offset_align_if.slave bus,
  output state_t o_dbg_state
);

  localparam int OFF_A_W = $clog2(A_W) + 1;
  localparam int OFF_B_W = $clog2(B_W) + 1;

  state_t             r_state;
  logic               r_cfg_ready;
  logic [OFF_A_W-1:0] r_off_a;
  logic [OFF_B_W-1:0] r_off_b;
  mode_t              r_mode;

  logic               r_s1_valid;
  logic [OUT_W-1:0]   r_s1_wa;
  logic [OUT_W-1:0]   r_s1_wb;
  logic               r_s1_ovf;

  logic               r_s2_valid;
  logic [OUT_W-1:0]   r_y;
  logic               r_ovf;
  logic [15:0]        r_cnt;

  logic [OUT_W-1:0]   w_wa;
  logic [OUT_W-1:0]   w_wb;
  logic               w_ovf_a;
  logic               w_ovf_b;
  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_in_ready;
  logic               w_accept;
  logic [OUT_W-1:0]   w_y;

  offset_slice #(.IN_W(A_W), .OUT_W(OUT_W)) u_slice_a (
    .i_data (bus.in_a),
    .i_off  (r_off_a),
    .o_win  (w_wa),
    .o_ovf  (w_ovf_a)
  );

  offset_slice #(.IN_W(B_W), .OUT_W(OUT_W)) u_slice_b (
    .i_data (bus.in_b),
    .i_off  (r_off_b),
    .o_win  (w_wb),
    .o_ovf  (w_ovf_b)
  );

  // A stage may load when it is empty or the stage after it is moving.
  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_in_ready = (r_state == RUN) && w_s1_adv;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Combine the S1 windows bit by bit, then apply the optional bit-0 force.
  always_comb begin
    w_y = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_y[i] = combine(r_s1_wa[i], r_s1_wb[i], r_mode);
    end
    if (FORCE_EN) begin
      w_y[0] = FORCE_VAL;
    end
  end

  // Control FSM: leave RUN on a config request, wait for an empty pipeline,
  // pulse cfg_ready for one cycle and latch the new config on that pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_cfg_ready <= 1'b0;
      r_off_a     <= OFF_A_W'(DEF_OFF_A);
      r_off_b     <= OFF_B_W'(DEF_OFF_B);
      r_mode      <= DEF_MODE;
    end else begin
      case (r_state)
        RUN: begin
          r_cfg_ready <= 1'b0;
          if (bus.cfg_valid) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_cfg_ready) begin
            r_off_a     <= bus.cfg_off_a;
            r_off_b     <= bus.cfg_off_b;
            r_mode      <= bus.cfg_mode;
            r_cfg_ready <= 1'b0;
            r_state     <= RUN;
          end else if (!r_s1_valid && !r_s2_valid) begin
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= RUN;
          r_cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture both windows and the overflow flag of an accepted pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_wa    <= '0;
      r_s1_wb    <= '0;
      r_s1_ovf   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_wa  <= w_wa;
        r_s1_wb  <= w_wb;
        r_s1_ovf <= w_ovf_a | w_ovf_b;
      end
    end
  end

  // Stage 2: register the combined result; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_ovf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y   <= w_y;
        r_ovf <= r_s1_ovf;
      end
    end
  end

  // Delivered-result counter, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_s2_valid && bus.out_ready) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_y     = r_y;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_cnt   = r_cnt;
  assign o_dbg_state   = r_state;

endmodule
